multi_alarm: RTL and testbench
==============================

Name: multi_alarm

Overview:
- Parametrised successor to the single-channel alarm.
- Holds NUM_ALARMS independently programmable alarm times and compares each against the running clock time.
- Drives a per-channel ringing vector plus an OR'd buzzer output. Adds auto-timeout, acknowledge, decrement editing and per-channel arming.
- Sits beside the clock counter and display mux; the display shows the alarm chosen by chan_sel.

Parameters:
- NUM_ALARMS, 4, number of alarm channels (1..16).
- RING_SECS, 60, number of tick_1hz pulses a channel rings before auto-stopping (1..255).
- SNOOZE_MIN, 5, minutes added on snooze (1..59); used only with MULTI_ALARM_SNOOZE_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- tick_1hz  in  1  single-cycle pulse once per second, from the clock divider
- sec_in  in  6  current clock seconds, 0..59
- min_in  in  6  current clock minutes, 0..59
- hour_in  in  5  current clock hours, 0..23
- chan_sel  in  CH_W  channel being edited/displayed; CH_W = max(1, clog2(NUM_ALARMS)); values >= NUM_ALARMS are ignored
- select  in  2  field select, SELECT_SEC / SELECT_MIN / SELECT_HOUR from shared constants; any other value means no field
- increment  in  1  level from debouncer; acts on rising edge
- decrement  in  1  level from debouncer; acts on rising edge
- arm  in  NUM_ALARMS  per-channel enable level
- ack  in  1  level; rising edge dismisses all ringing channels
- snooze  in  1  level; rising edge snoozes all ringing channels (feature-gated)
- disp_sec  out  6  alarm seconds of channel chan_sel
- disp_min  out  6  alarm minutes of channel chan_sel
- disp_hour  out  5  alarm hours of channel chan_sel
- ringing  out  NUM_ALARMS  per-channel ringing flag, registered
- out  out  1  OR of ringing, registered

Behaviour:
- Reset: all alarm times 00:00:00, all channels IDLE, ringing=0, out=0, edge-detect registers=0, ring counters=0. Display outputs are combinational off the stored time, so they read 0.
- Edge detect: increment, decrement, ack and snooze are each sampled into a prev register every cycle; an action fires on level & ~prev.
- Editing (channel chan_sel, field select):
  - Increment wraps 59->0 (sec/min) and 23->0 (hour).
  - Decrement wraps 0->59 (sec/min) and 0->23 (hour).
  - Increment and decrement edges in the same cycle: no change.
  - Invalid select or chan_sel: no change.
  - Editing is allowed in any state; it does not alter ringing.
- Match:
  - match[i] = (stored time == clock time).
  - trig[i] = match[i] & ~match_prev[i], so a channel fires once per matching second. Re-arming during the matching second does not fire.
- Per-channel FSM, states IDLE, ARMED, RINGING, SNOOZED:
  - IDLE -> ARMED when arm[i]=1.
  - Any state -> IDLE when arm[i]=0; ringing[i] drops the next cycle.
  - ARMED -> RINGING on trig[i]; ring counter cleared.
  - RINGING: the counter increments on tick_1hz. When counter==RING_SECS-1 and a tick arrives -> ARMED.
  - RINGING -> ARMED on an ack edge.
  - RINGING -> SNOOZED on a snooze edge (feature only).
  - SNOOZED -> RINGING when clock time equals the snooze target (edge-detected as for match). The original alarm match is ignored while SNOOZED.
  - SNOOZED -> ARMED on an ack edge (cancels snooze).
- Simultaneous events, priority highest first: disarm, ack, snooze, timeout, trig.
- Outputs: ringing[i] = (state==RINGING), registered. out = |ringing, registered in the same cycle as ringing.
- Latency: trig to ringing and out is 1 clk after the clock time changes.

Optional Feature:
- MULTI_ALARM_SNOOZE_EN defined:
  - The snooze edge stores target = clock time + SNOOZE_MIN minutes, seconds unchanged.
  - Minutes wrap at 60 with carry into hours; hours wrap 23->0.
  - The channel enters SNOOZED.
- Undefined:
  - The snooze port is present but ignored.
  - No SNOOZED state or target registers are synthesised.

Decomposition:
- Shared constants file (existing): SELECT_SEC/MIN/HOUR encodings, plus new FSM state encodings and time field widths (SEC_W=6, MIN_W=6, HOUR_W=5).
- Sub-module alarm_channel: one channel's stored time, inc/dec wrap logic, FSM, ring counter and snooze target.
- Top level: edge detection, the chan_sel decode to per-channel edit strobes, the display mux and the out OR-reduce.

Test Plan:
- Reset mid-ring: ch0 ringing, pulse reset -> ringing=0, out=0, all disp fields 0, ch0 IDLE.
- Edit wrap: chan_sel=2, select=SEC, one decrement edge from 0 -> disp_sec=59; select=HOUR, 24 increment edges -> disp_hour unchanged; inc+dec edges in the same cycle -> no change.
- Multi-fire: ch0 and ch1 both set to 07:30:00 and armed; clock reaches 07:30:00 -> ringing=2'b11 one cycle later, out=1. ack edge -> ringing=0, both channels ARMED, no refire during the same second.
- Timeout: RING_SECS=3, ch1 fires -> ringing[1] clears exactly on the 3rd tick_1hz.
- Disarm priority: ack and arm[0]=0 in the same cycle while ringing -> ch0 IDLE; clock later matches -> no ring.
- Snooze (MULTI_ALARM_SNOOZE_EN, SNOOZE_MIN=5): ring at 23:58:10, snooze edge -> ringing drops. Clock reaches 00:03:10 -> ringing re-asserts; ack -> ARMED.

Source files
------------

// File: rtl/multi_alarm_pkg.sv
// -----------------------------------------------------------------------------
// multi_alarm_pkg
// Shared constants for the alarm block: field-select encodings, time field
// widths, per-channel FSM state encoding, the packed alarm time type and the
// time arithmetic helpers used by the channels.
// -----------------------------------------------------------------------------
package multi_alarm_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [1:0] SELECT_SEC  = 2'd0;
    localparam logic [1:0] SELECT_MIN  = 2'd1;
    localparam logic [1:0] SELECT_HOUR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZED = 2'd3
    } alarm_state_e;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } alarm_time_t;

    localparam alarm_time_t TIME_ZERO = '{hour: 5'd0, min: 6'd0, sec: 6'd0};

    // One step up or down with wrap between 0 and max_val.
    function automatic logic [5:0] wrap_step(input logic [5:0] val,
                                             input logic [5:0] max_val,
                                             input logic       up);
        logic [5:0] res;
        if (up) begin
            if (val >= max_val) res = 6'd0;
            else                res = val + 6'd1;
        end else begin
            if (val == 6'd0)    res = max_val;
            else                res = val - 6'd1;
        end
        return res;
    endfunction

    // Add whole minutes to a time of day; seconds are kept, minutes carry
    // into hours and hours wrap after 23.
    function automatic alarm_time_t add_minutes(input alarm_time_t t,
                                                input logic [5:0]  mins);
        logic [6:0]  m_sum;
        alarm_time_t res;
        res   = t;
        m_sum = {1'b0, t.min} + {1'b0, mins};
        if (m_sum >= 7'd60) begin
            res.min = 6'(m_sum - 7'd60);
            if (t.hour >= 5'd23) res.hour = 5'd0;
            else                 res.hour = t.hour + 5'd1;
        end else begin
            res.min = m_sum[5:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/multi_alarm_if.sv
// -----------------------------------------------------------------------------
// multi_alarm_if
// Bundles every non-clock/reset signal of multi_alarm.
//   master : the environment (clock counter, debouncers, display side)
//   slave  : the multi_alarm block
// Inputs : tick_1hz, sec_in/min_in/hour_in (running time), chan_sel, select,
//          increment, decrement, arm[NUM_ALARMS], ack, snooze
// Outputs: disp_sec/min/hour (alarm time of chan_sel), ringing[NUM_ALARMS], out
// -----------------------------------------------------------------------------
interface multi_alarm_if
    import multi_alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4
);
    localparam int CH_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    logic                  tick_1hz;
    logic [SEC_W-1:0]      sec_in;
    logic [MIN_W-1:0]      min_in;
    logic [HOUR_W-1:0]     hour_in;
    logic [CH_W-1:0]       chan_sel;
    logic [1:0]            select;
    logic                  increment;
    logic                  decrement;
    logic [NUM_ALARMS-1:0] arm;
    logic                  ack;
    logic                  snooze;
    logic [SEC_W-1:0]      disp_sec;
    logic [MIN_W-1:0]      disp_min;
    logic [HOUR_W-1:0]     disp_hour;
    logic [NUM_ALARMS-1:0] ringing;
    logic                  out;

    modport master (
        output tick_1hz, sec_in, min_in, hour_in, chan_sel, select,
               increment, decrement, arm, ack, snooze,
        input  disp_sec, disp_min, disp_hour, ringing, out
    );

    modport slave (
        input  tick_1hz, sec_in, min_in, hour_in, chan_sel, select,
               increment, decrement, arm, ack, snooze,
        output disp_sec, disp_min, disp_hour, ringing, out
    );
endinterface

// File: rtl/multi_alarm_channel.sv
// -----------------------------------------------------------------------------
// alarm_channel
// One alarm channel: stored alarm time with inc/dec wrap editing, match edge
// detection, IDLE/ARMED/RINGING/SNOOZED FSM, ring timeout counter and (with
// MULTI_ALARM_SNOOZE_EN defined) the snooze target.
// Ports:
//   clk, reset      clock, async active-high reset
//   tick_1hz        one-cycle pulse per second
//   now_time        running clock time
//   select          field to edit
//   edit_up/edit_dn edit strobes for this channel (never both set)
//   arm             channel enable level
//   ack_evt         acknowledge edge
//   snooze_evt      snooze edge (ignored unless MULTI_ALARM_SNOOZE_EN)
//   alarm_time      stored alarm time
//   ring_next       ringing value being loaded this cycle
//   ringing         registered ringing flag
// -----------------------------------------------------------------------------
module alarm_channel
    import multi_alarm_pkg::*;
#(
    parameter int RING_SECS  = 60
`ifdef MULTI_ALARM_SNOOZE_EN
  , parameter int SNOOZE_MIN = 5
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  alarm_time_t now_time,
    input  logic [1:0]  select,
    input  logic        edit_up,
    input  logic        edit_dn,
    input  logic        arm,
    input  logic        ack_evt,
    input  logic        snooze_evt,
    output alarm_time_t alarm_time,
    output logic        ring_next,
    output logic        ringing
);

    localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

    alarm_time_t  alarm_r;
    alarm_state_e state_r;
    alarm_state_e state_next_s;
    logic [7:0]   ring_cnt_r;
    logic [7:0]   ring_cnt_next_s;
    logic         match_s;
    logic         match_prev_r;
    logic         trig_s;
    logic         ringing_r;
    logic         snz_en_s;
    logic         snz_trig_s;

    assign match_s = (alarm_r == now_time);
    assign trig_s  = match_s & ~match_prev_r;

`ifdef MULTI_ALARM_SNOOZE_EN
    alarm_time_t snz_target_r;
    logic        snz_match_s;
    logic        snz_match_prev_r;

    assign snz_en_s    = 1'b1;
    assign snz_match_s = (snz_target_r == now_time);
    assign snz_trig_s  = snz_match_s & ~snz_match_prev_r;

    // Snooze target captured on the RINGING -> SNOOZED transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snz_target_r     <= TIME_ZERO;
            snz_match_prev_r <= 1'b0;
        end else begin
            snz_match_prev_r <= snz_match_s;
            if ((state_r == ST_RINGING) && (state_next_s == ST_SNOOZED)) begin
                snz_target_r <= add_minutes(now_time, 6'(SNOOZE_MIN));
            end
        end
    end
`else
    // Without the feature the SNOOZED state is unreachable and optimised away.
    assign snz_en_s   = 1'b0;
    assign snz_trig_s = 1'b0;
`endif

    // Stored alarm time, edited one field at a time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_r <= TIME_ZERO;
        end else if (edit_up || edit_dn) begin
            case (select)
                SELECT_SEC:  alarm_r.sec  <= wrap_step(alarm_r.sec, 6'd59, edit_up);
                SELECT_MIN:  alarm_r.min  <= wrap_step(alarm_r.min, 6'd59, edit_up);
                SELECT_HOUR: alarm_r.hour <= 5'(wrap_step({1'b0, alarm_r.hour}, 6'd23, edit_up));
                default:     alarm_r      <= alarm_r;
            endcase
        end
    end

    // Next state and ring counter; priority disarm > ack > snooze > timeout > trig
    always_comb begin
        state_next_s    = state_r;
        ring_cnt_next_s = ring_cnt_r;
        if (!arm) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig_s) begin
                        state_next_s    = ST_RINGING;
                        ring_cnt_next_s = 8'd0;
                    end else begin
                        state_next_s = ST_ARMED;
                    end
                end
                ST_RINGING: begin
                    if (ack_evt) begin
                        state_next_s = ST_ARMED;
                    end else if (snooze_evt && snz_en_s) begin
                        state_next_s = ST_SNOOZED;
                    end else if (tick_1hz) begin
                        if (ring_cnt_r == RING_LAST) begin
                            state_next_s = ST_ARMED;
                        end else begin
                            ring_cnt_next_s = ring_cnt_r + 8'd1;
                        end
                    end else begin
                        state_next_s = ST_RINGING;
                    end
                end
                ST_SNOOZED: begin
                    if (ack_evt) begin
                        state_next_s = ST_ARMED;
                    end else if (snz_trig_s) begin
                        state_next_s    = ST_RINGING;
                        ring_cnt_next_s = 8'd0;
                    end else begin
                        state_next_s = ST_SNOOZED;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter, match history and registered ringing flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            ring_cnt_r   <= 8'd0;
            match_prev_r <= 1'b0;
            ringing_r    <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            ring_cnt_r   <= ring_cnt_next_s;
            match_prev_r <= match_s;
            ringing_r    <= (state_next_s == ST_RINGING);
        end
    end

    assign alarm_time = alarm_r;
    assign ring_next  = (state_next_s == ST_RINGING);
    assign ringing    = ringing_r;

endmodule

// File: rtl/multi_alarm.sv
// -----------------------------------------------------------------------------
// multi_alarm
// NUM_ALARMS independently programmable alarms compared against the running
// clock time. Button edge detection, chan_sel decode into per-channel edit
// strobes, display mux and the registered OR of all ringing flags live here.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    multi_alarm_if.slave (all time, edit, control and output signals)
// Optional feature: define MULTI_ALARM_SNOOZE_EN to enable snooze
// (ringing channels re-ring SNOOZE_MIN minutes later).
// A chan_sel beyond the last channel edits nothing and displays 00:00:00.
// -----------------------------------------------------------------------------
module multi_alarm
    import multi_alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input logic          clk,
    input logic          reset,
    multi_alarm_if.slave bus
);

    localparam int CH_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam logic [CH_W:0] NUM_EXT = (CH_W + 1)'(NUM_ALARMS);

`ifndef MULTI_ALARM_SNOOZE_EN
    localparam int snooze_min_unused = SNOOZE_MIN;
`endif

    logic inc_prev_r;
    logic dec_prev_r;
    logic ack_prev_r;
    logic snooze_prev_r;
    logic inc_edge_s;
    logic dec_edge_s;
    logic ack_edge_s;
    logic snooze_edge_s;
    logic step_up_s;
    logic step_dn_s;
    logic chan_valid_s;
    logic out_r;

    alarm_time_t           now_time_s;
    alarm_time_t           disp_time_s;
    alarm_time_t           alarm_time_s [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] chan_hit_s;
    logic [NUM_ALARMS-1:0] ring_next_s;
    logic [NUM_ALARMS-1:0] ring_s;

    // Previous button levels for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_prev_r    <= 1'b0;
            dec_prev_r    <= 1'b0;
            ack_prev_r    <= 1'b0;
            snooze_prev_r <= 1'b0;
        end else begin
            inc_prev_r    <= bus.increment;
            dec_prev_r    <= bus.decrement;
            ack_prev_r    <= bus.ack;
            snooze_prev_r <= bus.snooze;
        end
    end

    assign inc_edge_s    = bus.increment & ~inc_prev_r;
    assign dec_edge_s    = bus.decrement & ~dec_prev_r;
    assign ack_edge_s    = bus.ack & ~ack_prev_r;
    assign snooze_edge_s = bus.snooze & ~snooze_prev_r;

    // Simultaneous increment and decrement edges cancel.
    assign step_up_s = inc_edge_s & ~dec_edge_s;
    assign step_dn_s = dec_edge_s & ~inc_edge_s;

    assign chan_valid_s = ({1'b0, bus.chan_sel} < NUM_EXT);
    assign now_time_s   = {bus.hour_in, bus.min_in, bus.sec_in};

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_chan
        assign chan_hit_s[i] = chan_valid_s && (bus.chan_sel == CH_W'(i));

        alarm_channel #(
            .RING_SECS  (RING_SECS)
`ifdef MULTI_ALARM_SNOOZE_EN
          , .SNOOZE_MIN (SNOOZE_MIN)
`endif
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .tick_1hz   (bus.tick_1hz),
            .now_time   (now_time_s),
            .select     (bus.select),
            .edit_up    (step_up_s & chan_hit_s[i]),
            .edit_dn    (step_dn_s & chan_hit_s[i]),
            .arm        (bus.arm[i]),
            .ack_evt    (ack_edge_s),
            .snooze_evt (snooze_edge_s),
            .alarm_time (alarm_time_s[i]),
            .ring_next  (ring_next_s[i]),
            .ringing    (ring_s[i])
        );
    end

    // Display mux; chan_hit_s is one-hot or zero, so OR-ing the picks is exact
    always_comb begin
        disp_time_s = TIME_ZERO;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            disp_time_s = disp_time_s | (chan_hit_s[i] ? alarm_time_s[i] : TIME_ZERO);
        end
    end

    // Buzzer loaded from the same next values as the per-channel flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r <= 1'b0;
        end else begin
            out_r <= |ring_next_s;
        end
    end

    assign bus.disp_sec  = disp_time_s.sec;
    assign bus.disp_min  = disp_time_s.min;
    assign bus.disp_hour = disp_time_s.hour;
    assign bus.ringing   = ring_s;
    assign bus.out       = out_r;

endmodule

// File: tb/tb_multi_alarm.sv
`timescale 1ns/1ps
module tb_multi_alarm;
    import multi_alarm_pkg::*;

    localparam int NA = 3;
    localparam int RS = 3;
    localparam int SM = 5;
`ifdef MULTI_ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_RING = 2;
    localparam int M_SNZ  = 3;

    logic clk = 1'b0;
    logic reset;

    multi_alarm_if #(.NUM_ALARMS(NA)) ifc();

    multi_alarm #(.NUM_ALARMS(NA), .RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: alarm and target times as seconds of day
    int al  [NA];
    int tgt [NA];
    int st  [NA];
    int cnt [NA];
    bit mp  [NA];
    bit smp [NA];
    bit inc_p, dec_p, ack_p, snz_p;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin
            al[i] = 0; tgt[i] = 0; st[i] = M_IDLE; cnt[i] = 0; mp[i] = 0; smp[i] = 0;
        end
        inc_p = 0; dec_p = 0; ack_p = 0; snz_p = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_edge();
        int now, s, m, h;
        bit inc_e, dec_e, ack_e, snz_e, mt, tr, smt, str;
        now   = int'(ifc.hour_in) * 3600 + int'(ifc.min_in) * 60 + int'(ifc.sec_in);
        inc_e = ifc.increment && !inc_p;
        dec_e = ifc.decrement && !dec_p;
        ack_e = ifc.ack && !ack_p;
        snz_e = ifc.snooze && !snz_p;
        inc_p = ifc.increment; dec_p = ifc.decrement; ack_p = ifc.ack; snz_p = ifc.snooze;
        for (int i = 0; i < NA; i++) begin
            mt = (al[i] == now);   tr  = mt && !mp[i];   mp[i]  = mt;
            smt = (tgt[i] == now); str = smt && !smp[i]; smp[i] = smt;
            if (!ifc.arm[i]) st[i] = M_IDLE;
            else if (st[i] == M_IDLE) st[i] = M_ARM;
            else if (st[i] == M_ARM) begin
                if (tr) begin st[i] = M_RING; cnt[i] = 0; end
            end else if (st[i] == M_RING) begin
                if (ack_e) st[i] = M_ARM;
                else if (SNZ && snz_e) begin
                    st[i] = M_SNZ; tgt[i] = (now + SM * 60) % 86400;
                end else if (ifc.tick_1hz) begin
                    cnt[i]++;
                    if (cnt[i] == RS) st[i] = M_ARM;
                end
            end else begin
                if (ack_e) st[i] = M_ARM;
                else if (str) begin st[i] = M_RING; cnt[i] = 0; end
            end
        end
        if (int'(ifc.chan_sel) < NA && (inc_e != dec_e)) begin
            s = al[ifc.chan_sel] % 60;
            m = (al[ifc.chan_sel] / 60) % 60;
            h = al[ifc.chan_sel] / 3600;
            if (ifc.select == SELECT_SEC)       s = inc_e ? (s + 1) % 60 : (s + 59) % 60;
            else if (ifc.select == SELECT_MIN)  m = inc_e ? (m + 1) % 60 : (m + 59) % 60;
            else if (ifc.select == SELECT_HOUR) h = inc_e ? (h + 1) % 24 : (h + 23) % 24;
            al[ifc.chan_sel] = h * 3600 + m * 60 + s;
        end
    endtask

    task automatic compare_outputs();
        logic [NA-1:0] er;
        int d;
        for (int i = 0; i < NA; i++) er[i] = (st[i] == M_RING);
        d = (int'(ifc.chan_sel) < NA) ? al[ifc.chan_sel] : 0;
        check("ringing", ifc.ringing, er);
        check("out", ifc.out, |er);
        check("disp_sec", ifc.disp_sec, d % 60);
        check("disp_min", ifc.disp_min, (d / 60) % 60);
        check("disp_hour", ifc.disp_hour, d / 3600);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            model_edge();
            @(posedge clk);
            #1;
            compare_outputs();
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        ifc.hour_in = 5'(h); ifc.min_in = 6'(m); ifc.sec_in = 6'(s);
    endtask

    task automatic press(input bit up, input int n);
        for (int k = 0; k < n; k++) begin
            if (up) ifc.increment = 1'b1; else ifc.decrement = 1'b1;
            step(1);
            ifc.increment = 1'b0; ifc.decrement = 1'b0;
            step(1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, t;
        reset = 1'b1;
        ifc.tick_1hz = 1'b0; ifc.chan_sel = 2'd0; ifc.select = SELECT_SEC;
        ifc.increment = 1'b0; ifc.decrement = 1'b0; ifc.arm = 3'b000;
        ifc.ack = 1'b0; ifc.snooze = 1'b0;
        set_time(0, 0, 0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("reset_ringing", ifc.ringing, 3'b000);
        check("reset_out", ifc.out, 1'b0);
        check("reset_disp_sec", ifc.disp_sec, 6'd0);
        check("reset_disp_hour", ifc.disp_hour, 5'd0);
        reset = 1'b0;
        step(2);

        // Edit wrap on channel 2
        ifc.chan_sel = 2'd2; ifc.select = SELECT_SEC;
        press(1'b0, 1);
        check("dec_wrap_sec", ifc.disp_sec, 6'd59);
        ifc.select = SELECT_HOUR;
        press(1'b1, 24);
        check("inc_wrap_hour", ifc.disp_hour, 5'd0);
        ifc.increment = 1'b1; ifc.decrement = 1'b1; step(1);
        ifc.increment = 1'b0; ifc.decrement = 1'b0; step(1);
        check("inc_dec_cancel", ifc.disp_hour, 5'd0);
        ifc.select = 2'd3; press(1'b1, 1);
        ifc.chan_sel = 2'd3; ifc.select = SELECT_SEC; press(1'b1, 1);
        check("bad_chan_disp", ifc.disp_sec, 6'd0);
        ifc.chan_sel = 2'd2;
        step(1);
        check("bad_sel_no_edit", ifc.disp_sec, 6'd59);

        // Program channels 0 and 1 to 07:30:00
        for (int c = 0; c < 2; c++) begin
            ifc.chan_sel = 2'(c);
            ifc.select = SELECT_HOUR; press(1'b1, 7);
            ifc.select = SELECT_MIN;  press(1'b1, 30);
        end
        check("prog_min", ifc.disp_min, 6'd30);
        ifc.arm = 3'b011;
        set_time(7, 29, 59); step(2);
        set_time(7, 30, 0);  step(1);
        check("multi_fire", ifc.ringing, 3'b011);
        check("multi_out", ifc.out, 1'b1);
        ifc.ack = 1'b1; step(1);
        check("ack_clear", ifc.ringing, 3'b000);
        ifc.ack = 1'b0; step(3);
        check("no_refire", ifc.ringing, 3'b000);

        // Timeout after RS ticks
        set_time(7, 30, 1); step(1);
        set_time(7, 30, 0); step(1);
        for (int k = 0; k < RS; k++) begin
            check("before_timeout", ifc.ringing, 3'b011);
            ifc.tick_1hz = 1'b1; step(1);
            ifc.tick_1hz = 1'b0;
            if (k < RS - 1) step(1);
        end
        check("timeout_clear", ifc.ringing, 3'b000);
        step(1);

        // Disarm outranks ack
        set_time(7, 30, 1); step(1);
        set_time(7, 30, 0); step(1);
        check("refire", ifc.ringing, 3'b011);
        ifc.ack = 1'b1; ifc.arm = 3'b010; step(1);
        check("disarm_ack", ifc.ringing, 3'b000);
        ifc.ack = 1'b0; step(1);
        set_time(7, 30, 1); step(1);
        set_time(7, 30, 0); step(1);
        check("disarmed_silent", ifc.ringing, 3'b010);

        // Reset in the middle of a ring
        ifc.chan_sel = 2'd1;
        reset = 1'b1; #1;
        check("midreset_ringing", ifc.ringing, 3'b000);
        check("midreset_out", ifc.out, 1'b0);
        check("midreset_disp_min", ifc.disp_min, 6'd0);
        check("midreset_disp_hour", ifc.disp_hour, 5'd0);
        model_reset();
        #1 reset = 1'b0;
        step(2);

        // Snooze sequence on channel 0 (23:58:10)
        ifc.arm = 3'b000; ifc.chan_sel = 2'd0;
        ifc.select = SELECT_HOUR; press(1'b0, 1);
        ifc.select = SELECT_MIN;  press(1'b0, 2);
        ifc.select = SELECT_SEC;  press(1'b1, 10);
        ifc.arm = 3'b001;
        set_time(23, 58, 9); step(2);
        set_time(23, 58, 10); step(1);
        check("snooze_ring", ifc.ringing, 3'b001);
        ifc.snooze = 1'b1; step(1);
`ifdef MULTI_ALARM_SNOOZE_EN
        check("snooze_drop", ifc.ringing, 3'b000);
        ifc.snooze = 1'b0; step(1);
        set_time(0, 3, 9); step(2);
        set_time(0, 3, 10); step(1);
        check("snooze_rering", ifc.ringing, 3'b001);
`else
        check("snooze_ignored", ifc.ringing, 3'b001);
        ifc.snooze = 1'b0; step(1);
`endif
        ifc.ack = 1'b1; step(1);
        check("final_ack", ifc.ringing, 3'b000);
        ifc.ack = 1'b0; step(1);

        // Randomised phase against the model
        ifc.arm = 3'b111;
        t = 7 * 3600 + 30 * 60;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 49) == 0) ifc.arm[$urandom_range(0, NA - 1)] ^= 1'b1;
            ifc.increment = ($urandom_range(0, 3) == 0);
            ifc.decrement = ($urandom_range(0, 3) == 0);
            ifc.ack       = ($urandom_range(0, 9) == 0);
            ifc.snooze    = ($urandom_range(0, 9) == 0);
            ifc.tick_1hz  = ($urandom_range(0, 3) == 0);
            ifc.chan_sel  = 2'($urandom_range(0, 3));
            ifc.select    = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r >= 8)      t = $urandom_range(0, 86399);
            else if (r >= 5) t = ($urandom_range(0, 1) == 0) ? al[$urandom_range(0, NA - 1)]
                                                             : tgt[$urandom_range(0, NA - 1)];
            set_time(t / 3600, (t / 60) % 60, t % 60);
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
